// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART TX serializer, one bit per CLK: start, LSB-first data, optional parity, stop.
// Build option: define UART_TX_TWO_STOP_EN for a two-cycle stop bit.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state, w_state_n;
  logic                  r_tx, w_tx_n;
  logic                  r_busy, w_busy_n;
  logic [CW-1:0]         r_cnt, w_cnt_n;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_n;
  logic [DATA_WIDTH-1:0] r_data, w_data_n;
  logic                  r_pen, w_pen_n;
  logic                  r_ptyp, w_ptyp_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_pen   <= 1'b0;
      r_ptyp  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_busy_n;
      r_cnt   <= w_cnt_n;
      r_shift <= w_shift_n;
      r_data  <= w_data_n;
      r_pen   <= w_pen_n;
      r_ptyp  <= w_ptyp_n;
    end
  end

  // Outputs are registered, so each branch computes the bit for the next cycle.
  always_comb begin
    w_state_n = r_state;
    w_tx_n    = r_tx;
    w_busy_n  = r_busy;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_data_n  = r_data;
    w_pen_n   = r_pen;
    w_ptyp_n  = r_ptyp;
    case (r_state)
      IDLE: begin
        w_tx_n   = 1'b1;
        w_busy_n = 1'b0;
        if (DATA_VALID) begin
          w_data_n  = P_DATA;
          w_shift_n = P_DATA;
          w_pen_n   = PAR_EN;
          w_ptyp_n  = PAR_TYP;
          w_tx_n    = 1'b0;
          w_busy_n  = 1'b1;
          w_state_n = START;
        end
      end
      START: begin
        w_tx_n    = r_shift[0];
        w_shift_n = r_shift >> 1;
        w_cnt_n   = '0;
        w_state_n = DATA;
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_n = '0;
          if (r_pen) begin
            w_tx_n    = r_ptyp ? ~^r_data : ^r_data;
            w_state_n = PARITY;
          end else begin
            w_tx_n    = 1'b1;
            w_state_n = STOP;
          end
        end else begin
          w_tx_n    = r_shift[0];
          w_shift_n = r_shift >> 1;
          w_cnt_n   = r_cnt + 1'b1;
        end
      end
      PARITY: begin
        w_tx_n    = 1'b1;
        w_cnt_n   = '0;
        w_state_n = STOP;
      end
      STOP: begin
        w_tx_n = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
        if (r_cnt == '0) begin
          w_cnt_n = CW'(1);
        end else begin
          w_cnt_n   = '0;
          w_busy_n  = 1'b0;
          w_state_n = IDLE;
        end
`else
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
`endif
      end
      default: begin
        w_tx_n    = 1'b1;
        w_busy_n  = 1'b0;
        w_cnt_n   = '0;
        w_state_n = IDLE;
      end
    endcase
  end

  assign TX_OUT = r_tx;
  assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame (table vectors, corner sequences, random frames).
module tb_uart_tx_frame;

  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;
  bit exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] d;
    bit           pen;
    bit           ptyp;
    logic [15:0]  seq;
    int           len;
    string        name;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Expected line sequence derived from the frame rules: 0, data LSB first, parity, stop bits.
  function automatic void build(input logic [W-1:0] d, input bit pen, input bit ptyp);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pen) exp_q.push_back(ptyp ? ((ones % 2) == 0) : ((ones % 2) == 1));
    for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
  endfunction

  // Called at a negedge while the DUT is idle; returns at the negedge of the idle cycle after the frame.
  task automatic send(input logic [W-1:0] d, input bit pen, input bit ptyp,
                      input bit hold, input logic [W-1:0] nd, input string tag);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    DATA_VALID = 1'b1;
    @(posedge CLK);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge CLK);
      if (k == 0) begin
        if (hold) begin
          P_DATA = nd;
        end else begin
          DATA_VALID = 1'b0;
          P_DATA     = W'($urandom);
          PAR_EN     = 1'($urandom);
          PAR_TYP    = 1'($urandom);
        end
      end
      chk($sformatf("%s tx[%0d]", tag, k), TX_OUT, exp_q[k]);
      chk($sformatf("%s busy[%0d]", tag, k), busy, 1'b1);
    end
    @(negedge CLK);
    chk($sformatf("%s idle tx", tag), TX_OUT, 1'b1);
    chk($sformatf("%s idle busy", tag), busy, 1'b0);
  endtask

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 16'b0101001010, 10, "a5_even"};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 16'b0100000000, 10, "01_odd"};
    tbl[2] = '{8'h01, 1'b1, 1'b0, 16'b0100000001, 10, "01_even"};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 16'b011111111,   9, "ff_nopar"};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 16'b000000000,   9, "00_nopar"};

    repeat (2) @(negedge CLK);
    chk("reset tx", TX_OUT, 1'b1);
    chk("reset busy", busy, 1'b0);
    RST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("idle%0d tx", i), TX_OUT, 1'b1);
      chk($sformatf("idle%0d busy", i), busy, 1'b0);
    end

    for (int v = 0; v < 5; v++) begin
      exp_q.delete();
      for (int k = 0; k < tbl[v].len; k++) exp_q.push_back(tbl[v].seq[tbl[v].len - 1 - k]);
      for (int k = 0; k < NSTOP; k++) exp_q.push_back(1'b1);
      send(tbl[v].d, tbl[v].pen, tbl[v].ptyp, 1'b0, '0, tbl[v].name);
    end

    // Request held high across a frame while P_DATA changes: next frame after exactly one idle cycle.
    build(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 1'b1, 8'hC3, "hold_3c");
    build(8'hC3, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0, 1'b0, '0, "hold_c3");

    // Asynchronous reset while data bit 4 is on the line.
    build(8'h5A, 1'b1, 1'b1);
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
    @(posedge CLK);
    for (int k = 0; k <= 5; k++) begin
      @(negedge CLK);
      if (k == 0) DATA_VALID = 1'b0;
      chk($sformatf("pre_rst tx[%0d]", k), TX_OUT, exp_q[k]);
    end
    #2 RST = 1'b0;
    #1;
    chk("async rst tx", TX_OUT, 1'b1);
    chk("async rst busy", busy, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post_rst idle tx", TX_OUT, 1'b1);
    chk("post_rst idle busy", busy, 1'b0);
    send(8'h5A, 1'b1, 1'b1, 1'b0, '0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] d;
      bit pen, ptyp;
      int gap;
      d    = W'($urandom);
      pen  = 1'($urandom);
      ptyp = 1'($urandom);
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        chk($sformatf("rnd%0d gap tx", n), TX_OUT, 1'b1);
        chk($sformatf("rnd%0d gap busy", n), busy, 1'b0);
      end
      build(d, pen, ptyp);
      send(d, pen, ptyp, 1'b0, '0, $sformatf("rnd%0d_%02h", n, d));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
